// File: rtl/spdif_subframe_scheduler.sv
// spdif_subframe_scheduler: S/PDIF block/subframe sequencer with one-entry
// per-channel sample buffers and a registered subframe descriptor output.
module spdif_subframe_scheduler #(
   parameter int SLOTS  = 32,
   parameter int FRAMES = 192
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        bit_tick,
   input  logic [19:0] a_data,
   input  logic        a_valid,
   output logic        a_ready,
   input  logic [19:0] b_data,
   input  logic        b_valid,
   output logic        b_ready,
   input  logic [23:0] cs_word,
   input  logic        user_bit,
   output logic        sf_start,
   output logic [19:0] sf_data,
   output logic [1:0]  sf_pre,
   output logic        sf_v,
   output logic        sf_u,
   output logic        sf_c,
   output logic [7:0]  frame_idx,
   output logic        underrun,
   output logic        busy
);
   localparam int SW = $clog2(SLOTS);
   typedef enum logic {IDLE, RUN} state_t;
   state_t      state_q, state_d;
   logic [SW-1:0] slot_q, slot_d;
   logic        ch_q, ch_d;
   logic [7:0]  frame_q, frame_d;
   logic        a_full_q, a_full_d, b_full_q, b_full_d;
   logic [19:0] a_buf_q, a_buf_d, b_buf_q, b_buf_d;
   logic        sf_start_q, sf_start_d, underrun_q, underrun_d;
   logic [19:0] sf_data_q, sf_data_d;
   logic [1:0]  sf_pre_q, sf_pre_d;
   logic        sf_v_q, sf_v_d, sf_u_q, sf_u_d, sf_c_q, sf_c_d;
   logic [7:0]  sf_frame_q, sf_frame_d;
   logic        issue, last_slot, sel_full;
   always_comb begin
      state_d    = state_q;
      slot_d     = slot_q;
      ch_d       = ch_q;
      frame_d    = frame_q;
      sf_start_d = 1'b0;
      underrun_d = 1'b0;
      sf_data_d  = sf_data_q;
      sf_pre_d   = sf_pre_q;
      sf_v_d     = sf_v_q;
      sf_u_d     = sf_u_q;
      sf_c_d     = sf_c_q;
      sf_frame_d = sf_frame_q;
      issue      = 1'b0;
      last_slot  = slot_q == SW'(SLOTS - 1);
      sel_full   = ch_q ? b_full_q : a_full_q;
      if (state_q == IDLE) begin
         slot_d  = '0;
         ch_d    = 1'b0;
         frame_d = '0;
         if (en && bit_tick) begin
            state_d = RUN;
            issue   = 1'b1;
         end
      end else if (bit_tick) begin
         slot_d = last_slot ? '0 : slot_q + SW'(1);
         // Stopping is only honoured at an A boundary so a started frame always completes.
         if (last_slot && !ch_q && !en) begin
            state_d = IDLE;
            frame_d = '0;
         end else if (last_slot) begin
            issue = 1'b1;
         end
      end
      if (issue) begin
         sf_start_d = 1'b1;
         sf_frame_d = frame_q;
         sf_pre_d   = ch_q ? 2'b10 : (frame_q == '0 ? 2'b00 : 2'b01);
         sf_c_d     = frame_q < 8'd24 ? cs_word[frame_q[4:0]] : 1'b0;
         sf_u_d     = user_bit;
         sf_data_d  = sel_full ? (ch_q ? b_buf_q : a_buf_q) : '0;
         sf_v_d     = !sel_full;
         underrun_d = !sel_full;
         ch_d       = !ch_q;
         if (ch_q) frame_d = frame_q == 8'(FRAMES - 1) ? '0 : frame_q + 8'd1;
      end
      // Capture only into an empty buffer and consume only from a full one, so they never collide.
      a_full_d = a_full_q ? !(issue && !ch_q) : a_valid;
      b_full_d = b_full_q ? !(issue && ch_q) : b_valid;
      a_buf_d  = (a_valid && !a_full_q) ? a_data : a_buf_q;
      b_buf_d  = (b_valid && !b_full_q) ? b_data : b_buf_q;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         slot_q     <= '0;
         ch_q       <= 1'b0;
         frame_q    <= '0;
         a_full_q   <= 1'b0;
         b_full_q   <= 1'b0;
         a_buf_q    <= '0;
         b_buf_q    <= '0;
         sf_start_q <= 1'b0;
         underrun_q <= 1'b0;
         sf_data_q  <= '0;
         sf_pre_q   <= 2'b00;
         sf_v_q     <= 1'b0;
         sf_u_q     <= 1'b0;
         sf_c_q     <= 1'b0;
         sf_frame_q <= '0;
      end else begin
         state_q    <= state_d;
         slot_q     <= slot_d;
         ch_q       <= ch_d;
         frame_q    <= frame_d;
         a_full_q   <= a_full_d;
         b_full_q   <= b_full_d;
         a_buf_q    <= a_buf_d;
         b_buf_q    <= b_buf_d;
         sf_start_q <= sf_start_d;
         underrun_q <= underrun_d;
         sf_data_q  <= sf_data_d;
         sf_pre_q   <= sf_pre_d;
         sf_v_q     <= sf_v_d;
         sf_u_q     <= sf_u_d;
         sf_c_q     <= sf_c_d;
         sf_frame_q <= sf_frame_d;
      end
   end
   assign a_ready   = !a_full_q;
   assign b_ready   = !b_full_q;
   assign sf_start  = sf_start_q;
   assign sf_data   = sf_data_q;
   assign sf_pre    = sf_pre_q;
   assign sf_v      = sf_v_q;
   assign sf_u      = sf_u_q;
   assign sf_c      = sf_c_q;
   assign frame_idx = sf_frame_q;
   assign underrun  = underrun_q;
   assign busy      = state_q == RUN;
endmodule

// File: doc/spdif_subframe_scheduler.md
# spdif_subframe_scheduler

Sequencer for the optical S/PDIF transmit path. It owns the 192-frame block timing and accepts channel A and channel B samples through valid/ready handshakes into one-entry holding buffers. Once every 32 bit slots it issues a subframe descriptor: sample, preamble select, and V/U/C bits. The descriptor feeds the frame assembly/BMC stage, which serialises it.

## Interface
- `SLOTS`, default 32: bit-slot ticks per subframe.
- `FRAMES`, default 192: frames per channel-status block.
- `clk`, in, 1: system clock.
- `rst`, in, 1: synchronous reset, active-low (`rst`=0 resets).
- `en`, in, 1: transmit enable.
- `bit_tick`, in, 1: one-cycle strobe, one per bit slot.
- `a_data`, in, 20: channel A sample.
- `a_valid`, in, 1: channel A sample offered.
- `a_ready`, out, 1: channel A buffer empty.
- `b_data`, in, 20: channel B sample.
- `b_valid`, in, 1: channel B sample offered.
- `b_ready`, out, 1: channel B buffer empty.
- `cs_word`, in, 24: channel-status bits for frames 0..23.
- `user_bit`, in, 1: U bit value.
- `sf_start`, out, 1: one-cycle pulse; descriptor is new.
- `sf_data`, out, 20: subframe audio sample.
- `sf_pre`, out, 2: preamble select, 00=Z, 01=X, 10=Y.
- `sf_v`, out, 1: validity bit (1 = invalid sample).
- `sf_u`, out, 1: user bit.
- `sf_c`, out, 1: channel-status bit.
- `frame_idx`, out, 8: frame number of the current descriptor, 0..FRAMES-1.
- `underrun`, out, 1: one-cycle pulse; a subframe was issued from an empty buffer.
- `busy`, out, 1: scheduler is not in IDLE.

## Operation
- **Buffers:** each channel has a 1-entry register plus a full flag.
  - `x_ready` = !full.
  - Capture happens on `x_valid && x_ready`.
  - The flag is cleared when the scheduler consumes that channel.
- **States:** IDLE, RUN.
- **IDLE:**
  - `frame_idx`=0, channel pointer = A, slot counter = 0.
  - On `en && bit_tick`, this tick is the start tick of frame 0, channel A. Transition to RUN.
- **RUN:**
  - Slot counter increments on each `bit_tick`.
  - A tick with count == SLOTS-1 is the next start tick; the counter wraps to 0.
- **At a start tick for channel ch:**
  - If ch=A and `en`=0: go to IDLE and issue nothing.
  - Otherwise, load the descriptor:
    - `sf_pre`: Z if ch=A and frame 0; X if ch=A otherwise; Y if ch=B.
    - `sf_c` = `cs_word[frame_idx]` if `frame_idx` < 24, else 0. A and B get the same value.
    - `sf_u` = `user_bit`.
    - If the buffer is full: `sf_data` = buffer, `sf_v`=0, buffer flag cleared.
    - If the buffer is empty: `sf_data`=0, `sf_v`=1, `underrun` pulses.
  - After issuing B, `frame_idx` increments and wraps FRAMES-1 -> 0. The channel pointer toggles on every issue.
- **Stop behaviour:** deasserting `en` mid-frame still completes channel B. Buffers keep their contents across IDLE.

## Timing
- **Reset values:** `sf_start`=0, `sf_data`=0, `sf_pre`=00, `sf_v`=0, `sf_u`=0, `sf_c`=0, `frame_idx`=0, `underrun`=0, `busy`=0. Buffers are empty, so `a_ready`=`b_ready`=1 in the cycle after reset releases.
- **Descriptor latency:** `sf_start`, the descriptor and `underrun` are registered. They appear in the cycle after the start tick. The descriptor holds stable until the next `sf_start`.
- **Back-to-back samples:** `x_ready` rises in the cycle after consumption, so a new sample can be written then.
- **Capture vs. consume:**
  - A capture in the start-tick cycle while the buffer is empty is not bypassed. The underrun is reported and the sample is held for that channel's next subframe.
  - A capture is impossible while the buffer is full, so consume and capture never collide.
- **Tick without start:** a `bit_tick` in any cycle other than a start tick only advances the slot counter.
- **Reset mid-operation:**
  - Returns to IDLE immediately and empties both buffers.
  - Any `sf_start` pending for the next cycle is cancelled.

## Test plan
- **Basic streaming:** reset, `en`=1, `bit_tick` every 4 cycles, both buffers preloaded, `cs_word`=24'h000005. Expect:
  - `sf_start` every 32 ticks.
  - `sf_pre` sequence Z, Y, X, Y, X...
  - `sf_c` = 1, 1, 0, 0, 1, 1, 0, 0... for frames 0, 0, 1, 1, 2, 2...
- **Block wrap:** run 192 frames. Expect:
  - `frame_idx` 191 on the last B subframe, then 0 with `sf_pre`=Z.
  - `sf_c`=0 for frames 24..191.
- **Underrun:** withhold channel B for one frame. Expect the B subframe with `sf_data`=0, `sf_v`=1 and a one-cycle `underrun` pulse. Channel A is unaffected.
- **Start-tick write:** offer `a_data`=20'h12345 exactly on the channel A start tick with the buffer empty. Expect:
  - That subframe reports an underrun.
  - The next A subframe carries 12345 with `sf_v`=0.
  - `a_ready`=0 until then.
- **Stop:** drop `en` while channel A is being sent. Expect the B subframe still issued, then `busy`=0 at the next A start tick. Re-enabling restarts at Z with `frame_idx`=0.
- **Reset mid-run:** assert `rst`=0 for one cycle while the scheduler is running. Expect:
  - No `sf_start` afterwards.
  - All outputs at their reset values.
  - `a_ready`=`b_ready`=1.
